// File: rtl/eth_fcs_inserter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | eth_fcs_inserter : zero-pads short frames and appends IEEE 802.3 FCS      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module eth_fcs_inserter #(
   parameter int DATA_WIDTH      = 64,
   parameter int PAD_ENABLE      = 1,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
   input  logic [DATA_WIDTH/8-1:0]   S_AXIS_tkeep,
   input  logic                      S_AXIS_tvalid,
   input  logic                      S_AXIS_tlast,
   output logic                      S_AXIS_tready,
   output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
   output logic [DATA_WIDTH/8-1:0]   M_AXIS_tkeep,
   output logic                      M_AXIS_tvalid,
   output logic                      M_AXIS_tlast,
   input  logic                      M_AXIS_tready,
   output logic [15:0]               Frame_Count,
   output logic [31:0]               FCS_Last
);

   localparam int          c_BYTES = DATA_WIDTH / 8;
   localparam logic [31:0] c_POLY  = 32'hEDB88320;
   localparam logic [31:0] c_INIT  = 32'hFFFFFFFF;
   localparam logic [14:0] c_MIN   = 15'(MIN_FRAME_BYTES);

   typedef enum logic [1:0] {
      PASS = 2'd0,
      PAD  = 2'd1,
      FCS  = 2'd2
   } state_t;

   state_t       r_state, w_state_nxt;
   logic [31:0]  r_crc, w_crc_nxt;
   logic [13:0]  r_byte_cnt, w_byte_cnt_nxt;
   logic [31:0]  r_fcs, w_fcs_nxt;
   logic [3:0]   r_split, w_split_nxt;
   logic [63:0]  r_tdata, w_tdata_nxt;
   logic [7:0]   r_tkeep, w_tkeep_nxt;
   logic         r_tvalid, w_tvalid_nxt;
   logic         r_tlast, w_tlast_nxt;
   logic [15:0]  r_frame_count;
   logic [31:0]  r_fcs_last;

   logic         w_load, w_s_ready, w_s_fire;
   logic [3:0]   w_k, w_used;
   logic         w_emit, w_end, w_fill, w_fcs_beat;
   logic [63:0]  w_beat;
   logic [14:0]  w_len, w_rem, w_sum;
   logic [31:0]  w_crc_calc, w_fcs_val;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ c_POLY) : (c >> 1);
      return c;
   endfunction

   always_comb begin
      w_load    = !r_tvalid || M_AXIS_tready;
      w_s_ready = !ARESET && (r_state == PASS) && w_load;
      w_s_fire  = S_AXIS_tvalid && w_s_ready;

      w_k = 4'd0;
      for (int i = 0; i < c_BYTES; i++)
         if (S_AXIS_tkeep[i]) w_k = 4'(i + 1);

      // w_used = bytes of w_beat that precede the FCS; w_end = FCS starts in this beat
      w_emit     = 1'b0;
      w_end      = 1'b0;
      w_fill     = 1'b0;
      w_fcs_beat = 1'b0;
      w_beat     = 64'd0;
      w_used     = 4'd0;
      case (r_state)
         PASS: begin
            if (w_s_fire) begin
               w_emit = 1'b1;
               if (S_AXIS_tlast) begin
                  w_end  = 1'b1;
                  w_used = w_k;
                  for (int i = 0; i < c_BYTES; i++)
                     if (S_AXIS_tkeep[i]) w_beat[8*i +: 8] = S_AXIS_tdata[8*i +: 8];
               end else begin
                  w_used = 4'd8;
                  w_beat = S_AXIS_tdata;
               end
            end
         end
         PAD: begin
            if (w_load) begin
               w_emit = 1'b1;
               w_end  = 1'b1;
            end
         end
         FCS: begin
            if (w_load) w_fcs_beat = 1'b1;
         end
         default: ;
      endcase

      // Pad only up to the minimum: a beat that can reach it ends the padding itself
      w_len = {1'b0, r_byte_cnt} + {11'd0, w_used};
      w_rem = c_MIN - {1'b0, r_byte_cnt};
      if (w_end && (PAD_ENABLE != 0) && (w_len < c_MIN)) begin
         if (w_rem > 15'd8) begin
            w_end  = 1'b0;
            w_fill = 1'b1;
            w_used = 4'd8;
         end else begin
            w_used = w_rem[3:0];
         end
      end

      w_crc_calc = r_crc;
      for (int i = 0; i < c_BYTES; i++)
         if (4'(i) < w_used) w_crc_calc = crc_byte(w_crc_calc, w_beat[8*i +: 8]);
      w_fcs_val = ~w_crc_calc;
      w_sum     = {1'b0, r_byte_cnt} + {11'd0, w_used};

      w_state_nxt    = r_state;
      w_crc_nxt      = r_crc;
      w_byte_cnt_nxt = r_byte_cnt;
      w_fcs_nxt      = r_fcs;
      w_split_nxt    = r_split;
      w_tdata_nxt    = r_tdata;
      w_tkeep_nxt    = r_tkeep;
      w_tlast_nxt    = r_tlast;
      w_tvalid_nxt   = r_tvalid && !M_AXIS_tready;

      if (w_emit) begin
         w_tvalid_nxt = 1'b1;
         w_tdata_nxt  = w_beat;
         w_tkeep_nxt  = 8'hFF;
         w_tlast_nxt  = 1'b0;
         if (w_end) begin
            w_tdata_nxt    = w_beat | (64'(w_fcs_val) << {w_used, 3'b000});
            w_crc_nxt      = c_INIT;
            w_byte_cnt_nxt = 14'd0;
            w_fcs_nxt      = w_fcs_val;
            if (w_used <= 4'd4) begin
               for (int i = 0; i < c_BYTES; i++)
                  w_tkeep_nxt[i] = (4'(i) < (w_used + 4'd4));
               w_tlast_nxt = 1'b1;
               w_state_nxt = PASS;
            end else begin
               w_split_nxt = w_used;
               w_state_nxt = FCS;
            end
         end else begin
            w_crc_nxt      = w_crc_calc;
            w_byte_cnt_nxt = (w_sum > 15'h3FFF) ? 14'h3FFF : w_sum[13:0];
            if (w_fill) w_state_nxt = PAD;
         end
      end else if (w_fcs_beat) begin
         // Remaining FCS bytes are those that did not fit after byte r_split-1
         w_tvalid_nxt = 1'b1;
         w_tdata_nxt  = {32'd0, r_fcs >> {(4'd8 - r_split), 3'b000}};
         for (int i = 0; i < c_BYTES; i++)
            w_tkeep_nxt[i] = (4'(i) < (r_split - 4'd4));
         w_tlast_nxt  = 1'b1;
         w_state_nxt  = PASS;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state       <= PASS;
         r_crc         <= c_INIT;
         r_byte_cnt    <= 14'd0;
         r_fcs         <= 32'd0;
         r_split       <= 4'd0;
         r_tdata       <= 64'd0;
         r_tkeep       <= 8'd0;
         r_tvalid      <= 1'b0;
         r_tlast       <= 1'b0;
         r_frame_count <= 16'd0;
         r_fcs_last    <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_crc      <= w_crc_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_fcs      <= w_fcs_nxt;
         r_split    <= w_split_nxt;
         r_tdata    <= w_tdata_nxt;
         r_tkeep    <= w_tkeep_nxt;
         r_tvalid   <= w_tvalid_nxt;
         r_tlast    <= w_tlast_nxt;
         if (r_tvalid && r_tlast && M_AXIS_tready) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_fcs_last    <= r_fcs;
         end
      end
   end

   assign S_AXIS_tready = w_s_ready;
   assign M_AXIS_tdata  = r_tdata;
   assign M_AXIS_tkeep  = r_tkeep;
   assign M_AXIS_tvalid = r_tvalid;
   assign M_AXIS_tlast  = r_tlast;
   assign Frame_Count   = r_frame_count;
   assign FCS_Last      = r_fcs_last;

endmodule
`default_nettype wire

// File: tb/tb_eth_fcs_inserter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_eth_fcs_inserter : directed bench, unpadded and padded instances      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_eth_fcs_inserter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        toggle_en = 1'b0;
   logic        m_tready = 1'b1;
   logic [63:0] s_tdata = '0;
   logic [7:0]  s_tkeep = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;

   logic        n_s_tready, p_s_tready, n_m_tvalid, p_m_tvalid, n_m_tlast, p_m_tlast;
   logic [63:0] n_m_tdata, p_m_tdata;
   logic [7:0]  n_m_tkeep, p_m_tkeep;
   logic [15:0] n_fc, p_fc;
   logic [31:0] n_fcs, p_fcs;

   logic        a_s_tready, a_m_tvalid, a_m_tlast;
   logic [63:0] a_m_tdata;
   logic [7:0]  a_m_tkeep;
   logic [15:0] a_fc;
   logic [31:0] a_fcs;

   assign a_s_tready = sel ? p_s_tready : n_s_tready;
   assign a_m_tvalid = sel ? p_m_tvalid : n_m_tvalid;
   assign a_m_tlast  = sel ? p_m_tlast  : n_m_tlast;
   assign a_m_tdata  = sel ? p_m_tdata  : n_m_tdata;
   assign a_m_tkeep  = sel ? p_m_tkeep  : n_m_tkeep;
   assign a_fc       = sel ? p_fc       : n_fc;
   assign a_fcs      = sel ? p_fcs      : n_fcs;

   eth_fcs_inserter #(.DATA_WIDTH(64), .PAD_ENABLE(0), .MIN_FRAME_BYTES(60)) dut_nopad (
      .ACLK(clk), .ARESET(rst),
      .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(s_tvalid),
      .S_AXIS_tlast(s_tlast), .S_AXIS_tready(n_s_tready),
      .M_AXIS_tdata(n_m_tdata), .M_AXIS_tkeep(n_m_tkeep), .M_AXIS_tvalid(n_m_tvalid),
      .M_AXIS_tlast(n_m_tlast), .M_AXIS_tready(m_tready),
      .Frame_Count(n_fc), .FCS_Last(n_fcs)
   );

   eth_fcs_inserter #(.DATA_WIDTH(64), .PAD_ENABLE(1), .MIN_FRAME_BYTES(60)) dut_pad (
      .ACLK(clk), .ARESET(rst),
      .S_AXIS_tdata(s_tdata), .S_AXIS_tkeep(s_tkeep), .S_AXIS_tvalid(s_tvalid),
      .S_AXIS_tlast(s_tlast), .S_AXIS_tready(p_s_tready),
      .M_AXIS_tdata(p_m_tdata), .M_AXIS_tkeep(p_m_tkeep), .M_AXIS_tvalid(p_m_tvalid),
      .M_AXIS_tlast(p_m_tlast), .M_AXIS_tready(m_tready),
      .Frame_Count(p_fc), .FCS_Last(p_fcs)
   );

   always #5 clk = ~clk;

   // Downstream ready changes just after each rising edge so it is stable at the falling edge
   always @(posedge clk) begin
      #2;
      m_tready = toggle_en ? ~m_tready : 1'b1;
   end

   int total = 0;
   int bad   = 0;

   logic [63:0] out_d[$];
   logic [7:0]  out_k[$];
   logic        out_l[$];
   int          out_c[$];
   int          cyc = 0;
   int          stab_err = 0;
   int          kerr = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] pd = '0;
   logic [7:0]  pk = '0;
   logic        pl = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (prev_stall && !(a_m_tvalid === 1'b1 && a_m_tdata === pd && a_m_tkeep === pk && a_m_tlast === pl))
         stab_err++;
      if (a_m_tvalid && m_tready && !rst) begin
         out_d.push_back(a_m_tdata);
         out_k.push_back(a_m_tkeep);
         out_l.push_back(a_m_tlast);
         out_c.push_back(cyc);
         if ((((a_m_tkeep + 8'd1) & a_m_tkeep) != 8'd0) || (!a_m_tlast && a_m_tkeep != 8'hFF))
            kerr++;
      end
      prev_stall = a_m_tvalid && !m_tready && !rst;
      pd = a_m_tdata;
      pk = a_m_tkeep;
      pl = a_m_tlast;
   end

   logic [7:0]  frm[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   logic [31:0] exp_fcs;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      assert (got === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic clear_all();
      out_d.delete(); out_k.delete(); out_l.delete(); out_c.delete();
      exp_q.delete(); frm.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
      int n;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
      n = 0;
      while (!a_s_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("s_tready_timeout", 64'(n), 64'd0);
      @(negedge clk);
      s_tvalid = 1'b0;
   endtask

   task automatic send_frame(input bit gaps, input bit empty_last);
      int nb;
      nb = (frm.size() + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         logic [63:0] d;
         logic [7:0]  k;
         d = '0;
         k = '0;
         for (int i = 0; i < 8; i++)
            if (b * 8 + i < frm.size()) begin
               d[8*i +: 8] = frm[b * 8 + i];
               k[i] = 1'b1;
            end
         if (gaps && (b % 2 == 1)) @(negedge clk);
         drive_beat(d, k, (b == nb - 1) && !empty_last);
      end
      if (empty_last) drive_beat(64'd0, 8'h00, 1'b1);
   endtask

   task automatic wait_frames(input string tag, input logic [15:0] target);
      int n;
      n = 0;
      while (a_fc !== target && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(a_fc), 64'(target));
      repeat (2) @(negedge clk);
   endtask

   // Reference: bit-serial reflected CRC-32 over frame, zero pad to 60 when enabled
   task automatic build_expected(input bit pad);
      logic [31:0] crc;
      logic [7:0]  b;
      int          n;
      crc = 32'hFFFFFFFF;
      n = frm.size();
      if (pad && n < 60) n = 60;
      for (int i = 0; i < n; i++) begin
         b = (i < frm.size()) ? frm[i] : 8'h00;
         exp_q.push_back(b);
         for (int j = 0; j < 8; j++)
            if (crc[0] ^ b[j]) crc = (crc >> 1) ^ 32'hEDB88320;
            else               crc = crc >> 1;
      end
      exp_fcs = ~crc;
      for (int j = 0; j < 4; j++) exp_q.push_back(exp_fcs[8*j +: 8]);
   endtask

   task automatic check_stream(input string tag, input int exp_beats, input int exp_lasts);
      int mism;
      int lasts;
      mism = 0;
      lasts = 0;
      got_q.delete();
      foreach (out_d[b]) begin
         for (int i = 0; i < 8; i++)
            if (out_k[b][i]) got_q.push_back(out_d[b][8*i +: 8]);
         if (out_l[b]) lasts++;
      end
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
      check({tag, "_beats"}, 64'(out_d.size()), 64'(exp_beats));
      check({tag, "_bytes"}, 64'(got_q.size()), 64'(exp_q.size()));
      check({tag, "_byte_mism"}, 64'(mism), 64'd0);
      check({tag, "_tlasts"}, 64'(lasts), 64'(exp_lasts));
   endtask

   task automatic set_frame(input int len, input int seed);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'((i * 7 + seed) & 255));
   endtask

   task automatic frame_123456789(input string tag, input logic [15:0] fc_after);
      clear_all();
      drive_beat(64'h3837363534333231, 8'hFF, 1'b0);
      check({tag, "_latency_tvalid"}, 64'(a_m_tvalid), 64'd1);
      drive_beat(64'h0000000000000039, 8'h01, 1'b1);
      wait_frames({tag, "_frame_count"}, fc_after);
      check({tag, "_nbeats"}, 64'(out_d.size()), 64'd2);
      check({tag, "_beat0_data"}, (out_d.size() > 0) ? out_d[0] : 64'hX, 64'h3837363534333231);
      check({tag, "_beat0_last"}, (out_l.size() > 0) ? 64'(out_l[0]) : 64'hX, 64'd0);
      check({tag, "_beat1_data"}, (out_d.size() > 1) ? {24'd0, out_d[1][39:0]} : 64'hX, 64'h000000CBF4392639);
      check({tag, "_beat1_keep"}, (out_k.size() > 1) ? 64'(out_k[1]) : 64'hX, 64'h1F);
      check({tag, "_beat1_last"}, (out_l.size() > 1) ? 64'(out_l[1]) : 64'hX, 64'd1);
      check({tag, "_fcs_last"}, 64'(a_fcs), 64'hCBF43926);
   endtask

   initial begin
      // Reset state, unpadded instance
      sel = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_s_tready", 64'(a_s_tready), 64'd0);
      check("rst_m_tvalid", 64'(a_m_tvalid), 64'd0);
      check("rst_m_tlast",  64'(a_m_tlast),  64'd0);
      check("rst_m_tdata_keep", {a_m_tkeep, a_m_tdata[55:0]}, 64'd0);
      check("rst_frame_count", 64'(a_fc), 64'd0);
      check("rst_fcs_last", 64'(a_fcs), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      frame_123456789("t1", 16'd1);

      // k=4 on the last beat: FCS fills the beat exactly
      clear_all(); set_frame(12, 3); build_expected(1'b0);
      send_frame(1'b0, 1'b0);
      wait_frames("k4_frame_count", 16'd2);
      check_stream("k4", 2, 1);
      check("k4_last_keep", (out_k.size() > 1) ? 64'(out_k[1]) : 64'hX, 64'hFF);
      check("k4_fcs_last", 64'(a_fcs), 64'(exp_fcs));

      // tkeep=0 on the tlast beat
      clear_all(); set_frame(8, 11); build_expected(1'b0);
      send_frame(1'b0, 1'b1);
      wait_frames("k0_frame_count", 16'd3);
      check_stream("k0", 2, 1);
      check("k0_last_keep", (out_k.size() > 1) ? 64'(out_k[1]) : 64'hX, 64'h0F);

      // Single-beat frame
      clear_all(); set_frame(3, 40); build_expected(1'b0);
      send_frame(1'b0, 1'b0);
      wait_frames("single_frame_count", 16'd4);
      check_stream("single", 1, 1);
      check("single_keep", (out_k.size() > 0) ? 64'(out_k[0]) : 64'hX, 64'h7F);

      // Reset after 3 beats of a frame, then a clean frame
      clear_all(); set_frame(24, 5);
      for (int b = 0; b < 3; b++) begin
         logic [63:0] d;
         for (int i = 0; i < 8; i++) d[8*i +: 8] = frm[b * 8 + i];
         drive_beat(d, 8'hFF, 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("abort_frame_count", 64'(a_fc), 64'd0);
      check("abort_m_tvalid", 64'(a_m_tvalid), 64'd0);
      begin
         int lasts;
         lasts = 0;
         foreach (out_l[b]) if (out_l[b]) lasts++;
         check("abort_no_tlast", 64'(lasts), 64'd0);
      end
      frame_123456789("after_abort", 16'd1);

      // Padded instance
      sel = 1'b1;
      clear_all();
      do_reset();

      // 1-byte frame padded to 60
      clear_all(); frm.push_back(8'hAB); build_expected(1'b1);
      send_frame(1'b0, 1'b0);
      wait_frames("pad1_frame_count", 16'd1);
      check_stream("pad1", 8, 1);
      check("pad1_last_keep", (out_k.size() > 7) ? 64'(out_k[7]) : 64'hX, 64'hFF);
      check("pad1_last_flag", (out_l.size() > 7) ? 64'(out_l[7]) : 64'hX, 64'd1);
      check("pad1_fcs_last", 64'(a_fcs), 64'(exp_fcs));

      // 61 bytes: FCS split across two beats
      clear_all(); set_frame(61, 17); build_expected(1'b1);
      send_frame(1'b0, 1'b0);
      wait_frames("f61_frame_count", 16'd2);
      check_stream("f61", 9, 1);
      check("f61_beat7_last", (out_l.size() > 7) ? 64'(out_l[7]) : 64'hX, 64'd0);
      check("f61_beat8_keep", (out_k.size() > 8) ? 64'(out_k[8]) : 64'hX, 64'h01);

      // 57 bytes: pad completes inside the last data beat
      clear_all(); set_frame(57, 99); build_expected(1'b1);
      send_frame(1'b0, 1'b0);
      wait_frames("f57_frame_count", 16'd3);
      check_stream("f57", 8, 1);
      check("f57_fcs_last", 64'(a_fcs), 64'(exp_fcs));

      // 64 bytes with downstream stalls and source gaps
      clear_all(); set_frame(64, 201); build_expected(1'b1);
      toggle_en = 1'b1;
      send_frame(1'b1, 1'b0);
      wait_frames("stall_frame_count", 16'd4);
      toggle_en = 1'b0;
      repeat (3) @(negedge clk);
      check_stream("stall", 9, 1);
      check("stall_last_keep", (out_k.size() > 8) ? 64'(out_k[8]) : 64'hX, 64'h0F);
      check("stall_hold_errors", 64'(stab_err), 64'd0);

      // Two back-to-back 60-byte frames
      clear_all();
      do_reset();
      set_frame(60, 1); build_expected(1'b1);
      send_frame(1'b0, 1'b0);
      set_frame(60, 77); build_expected(1'b1);
      send_frame(1'b0, 1'b0);
      wait_frames("b2b_frame_count", 16'd2);
      check_stream("b2b", 16, 2);
      check("b2b_no_idle", (out_c.size() == 16) ? 64'(out_c[15] - out_c[0]) : 64'hX, 64'd15);
      check("b2b_fcs_last", 64'(a_fcs), 64'(exp_fcs));

      check("keep_shape_errors", 64'(kerr), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
